// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - shared state/requester types and parameter defaults for data_mem_arbiter
package data_mem_arb_pkg;

    localparam int ADDR_W_DEFAULT    = 10;
    localparam int BURST_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        DMA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DMA  = 1'b1
    } req_id_t;

endpackage

// File: rtl/arb_burst_counter.sv
// rtl/arb_burst_counter.sv - counts consecutive DMA beats; clear together with inc restarts at 1
module arb_burst_counter #(
    parameter int BURST_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic at_limit
);

    localparam int CW = $clog2(BURST_MAX + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= inc ? CW'(1) : '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign at_limit = (count == CW'(BURST_MAX));

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - core/DMA data-memory arbiter, round-robin with DMA bursts
// Define DATA_MEM_ARB_FIXED_PRIO_EN for strict core priority (BURST_MAX then unused).
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        coreReq,
    input  logic        coreWe,
    input  logic [31:0] coreAddr,
    input  logic [31:0] coreWdata,
    output logic        coreGnt,
    output logic        coreRvalid,
    output logic [31:0] coreRdata,
    input  logic        dmaReq,
    input  logic        dmaWe,
    input  logic [31:0] dmaAddr,
    input  logic [31:0] dmaWdata,
    output logic        dmaGnt,
    output logic        dmaRvalid,
    output logic [31:0] dmaRdata,
    output logic        memWrite,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    output logic        busy
);

    arb_state_t state, state_next;
    req_id_t    last_gnt;

    // Upper address bits are deliberately dropped: addresses wrap into the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{coreAddr[31:ADDR_W], dmaAddr[31:ADDR_W]};

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        state_next = IDLE;
        if (coreReq) begin
            state_next = CORE;
        end else if (dmaReq) begin
            state_next = DMA;
        end
    end
`else
    logic burst_at_limit;
    logic dma_continue;

    always_comb begin
        state_next = IDLE;
        if (coreReq && dmaReq) begin
            if (state == DMA && !burst_at_limit) begin
                state_next = DMA;
            end else if (last_gnt == REQ_DMA) begin
                state_next = CORE;
            end else begin
                state_next = DMA;
            end
        end else if (coreReq) begin
            state_next = CORE;
        end else if (dmaReq) begin
            state_next = DMA;
        end
    end

    // A DMA beat either extends the running burst or starts a fresh one at count 1.
    assign dma_continue = (state == DMA) && (state_next == DMA) && !burst_at_limit;

    arb_burst_counter #(
        .BURST_MAX (BURST_MAX)
    ) u_burst_counter (
        .clk      (clk),
        .reset    (reset),
        .inc      (state_next == DMA),
        .clear    (!dma_continue),
        .at_limit (burst_at_limit)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt     <= REQ_DMA;
            memWrite     <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            coreRvalid   <= 1'b0;
            dmaRvalid    <= 1'b0;
        end else begin
            coreRvalid <= (state == CORE) && !memWrite;
            dmaRvalid  <= (state == DMA) && !memWrite;
            memWrite   <= 1'b0;
            case (state_next)
                CORE: begin
                    last_gnt     <= REQ_CORE;
                    memWrite     <= coreWe;
                    memAddress   <= {{(32-ADDR_W){1'b0}}, coreAddr[ADDR_W-1:0]};
                    memWriteData <= coreWdata;
                end
                DMA: begin
                    last_gnt     <= REQ_DMA;
                    memWrite     <= dmaWe;
                    memAddress   <= {{(32-ADDR_W){1'b0}}, dmaAddr[ADDR_W-1:0]};
                    memWriteData <= dmaWdata;
                end
                default: ;
            endcase
        end
    end

    assign coreGnt   = (state == CORE);
    assign dmaGnt    = (state == DMA);
    assign busy      = (state != IDLE);
    assign coreRdata = coreRvalid ? memReadData : '0;
    assign dmaRdata  = dmaRvalid ? memReadData : '0;

endmodule
